// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder slice: FSM encoding,
// word geometry, and the alignment helper used by the responder.
package mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int ADDR_LSB   = 2;
  localparam int WORD_BYTES = 4;

  // A byte address is usable only when it lands on a whole word boundary.
  function automatic logic isAligned(input logic [31:0] addr);
    return (addr & 32'(WORD_BYTES - 1)) == 32'd0;
  endfunction

endpackage

// File: rtl/word_ram.sv
// Word-addressed storage array: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module word_ram #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [WIDTH-1:0]      i_wdata,
  output logic [WIDTH-1:0]      o_rdata
);

  logic [WIDTH-1:0] r_mem [0:(2**DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the multi-cycle CPU: accepts one word request,
// waits LATENCY cycles, then pulses a response with read data and error flag.
module mem_responder
  import mem_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 6,
  parameter int LATENCY    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [31:0]      req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             req_ready,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err
);

  localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LAT_INIT = CW'(LATENCY);

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic             r_ready;
  logic             r_resp_valid;
  logic [WIDTH-1:0] r_rdata;
  logic             r_err;

  logic             w_enter_resp;
  logic             w_cur_we;
  logic [31:0]      w_cur_addr;
  logic [WIDTH-1:0] w_cur_wdata;
  logic             w_aligned;
  logic             w_ram_we;
  logic [WIDTH-1:0] w_ram_rdata;

  // With zero latency RESP is entered on the accept edge itself, so the
  // array must see the live request rather than the not-yet-latched copy.
  assign w_enter_resp = ((r_state == S_IDLE) && req_valid && (LATENCY == 0)) ||
                        ((r_state == S_BUSY) && (r_count == '0));
  assign w_cur_we     = (r_state == S_IDLE) ? req_we    : r_we;
  assign w_cur_addr   = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_cur_wdata  = (r_state == S_IDLE) ? req_wdata : r_wdata;
  assign w_aligned    = isAligned(w_cur_addr);
  assign w_ram_we     = w_enter_resp && w_cur_we && w_aligned && !reset;

  word_ram #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_cur_addr[DEPTH_LOG2+ADDR_LSB-1:ADDR_LSB]),
    .i_wdata (w_cur_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_count <= LAT_INIT;
            r_ready <= 1'b0;
            if (LATENCY == 0) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
            end else begin
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (r_count == '0) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        S_RESP: begin
          r_state      <= S_IDLE;
          r_ready      <= 1'b1;
          r_resp_valid <= 1'b0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_ready      <= 1'b1;
          r_resp_valid <= 1'b0;
        end
      endcase

      // Read data is the pre-write contents; misaligned requests return zero.
      if (w_enter_resp) begin
        r_rdata <= w_aligned ? w_ram_rdata : '0;
        r_err   <= !w_aligned;
      end
    end
  end

  assign req_ready  = r_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one LATENCY=2 instance for functional and
// abort checks, one LATENCY=0 instance for back-to-back throughput.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;

  logic        reqValid, reqWe, reqReady, respValid, respErr;
  logic [31:0] reqAddr, reqWdata, respRdata;

  logic        zValid, zWe, zReady, zRespValid, zRespErr;
  logic [31:0] zAddr, zWdata, zRespRdata;

  int          checks   = 0;
  int          failures = 0;

  logic [31:0] gotData;
  logic        gotErr;
  int          gotCycle;
  logic        readyLeak;
  logic        afterValid;
  logic        afterReady;
  logic        seenResp;

  always #5 clk = ~clk;

  mem_responder #(.WIDTH(32), .DEPTH_LOG2(6), .LATENCY(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (reqValid),
    .req_we     (reqWe),
    .req_addr   (reqAddr),
    .req_wdata  (reqWdata),
    .req_ready  (reqReady),
    .resp_valid (respValid),
    .resp_rdata (respRdata),
    .resp_err   (respErr)
  );

  mem_responder #(.WIDTH(32), .DEPTH_LOG2(6), .LATENCY(0)) dutZero (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (zValid),
    .req_we     (zWe),
    .req_addr   (zAddr),
    .req_wdata  (zWdata),
    .req_ready  (zReady),
    .resp_valid (zRespValid),
    .resp_rdata (zRespRdata),
    .resp_err   (zRespErr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One full transaction on the LATENCY=2 instance; gotCycle is the number of
  // falling edges after the accept edge at which resp_valid was first seen.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    @(negedge clk);
    reqWe    = we;
    reqAddr  = addr;
    reqWdata = wdata;
    reqValid = 1'b1;
    n = 0;
    while (!reqReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!reqReady) begin
      checkBit("readyTimeout", reqReady, 1'b1);
      reqValid = 1'b0;
      gotCycle = -1;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    reqValid  = 1'b0;
    gotCycle  = -1;
    readyLeak = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (reqReady) readyLeak = 1'b1;
      if (respValid) begin
        gotCycle = k;
        gotData  = respRdata;
        gotErr   = respErr;
        break;
      end
      @(negedge clk);
    end
    if (gotCycle < 0) begin
      checkBit("respTimeout", respValid, 1'b1);
    end else begin
      @(negedge clk);
      afterValid = respValid;
      afterReady = reqReady;
    end
  endtask

  initial begin
    reset    = 1'b1;
    reqValid = 1'b0; reqWe = 1'b0; reqAddr = '0; reqWdata = '0;
    zValid   = 1'b0; zWe   = 1'b0; zAddr   = '0; zWdata   = '0;

    @(negedge clk);
    checkBit("rstReady", reqReady, 1'b1);
    checkBit("rstValid", respValid, 1'b0);
    checkOutput("rstRdata", respRdata, 32'h0);
    checkBit("rstErr", respErr, 1'b0);
    checkBit("rstZeroValid", zRespValid, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Preload word 1 with zero, then abort a write to it with reset.
    applyStimulus(1'b1, 32'h04, 32'h0);
    checkBit("preloadErr", gotErr, 1'b0);

    @(negedge clk);
    reqWe = 1'b1; reqAddr = 32'h04; reqWdata = 32'h12345678; reqValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    seenResp = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (respValid) seenResp = 1'b1;
    end
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (respValid) seenResp = 1'b1;
    end
    checkBit("abortNoResp", seenResp, 1'b0);
    checkOutput("abortRdata", respRdata, 32'h0);
    checkBit("abortErr", respErr, 1'b0);
    checkBit("abortReady", reqReady, 1'b1);
    applyStimulus(1'b0, 32'h04, 32'h0);
    checkOutput("abortNoCommit", gotData, 32'h0);

    // Write then read with LATENCY=2 timing checks.
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF);
    checkOutput("wrCycle", 32'(gotCycle), 32'd4);
    checkBit("wrReadyLow", readyLeak, 1'b0);
    checkBit("wrPulseEnds", afterValid, 1'b0);
    checkBit("wrReadyBack", afterReady, 1'b1);
    applyStimulus(1'b0, 32'h10, 32'h0);
    checkOutput("rdData10", gotData, 32'hDEADBEEF);
    checkBit("rdErr10", gotErr, 1'b0);

    // A write returns the contents it replaces.
    applyStimulus(1'b1, 32'h20, 32'h11111111);
    applyStimulus(1'b1, 32'h20, 32'hAAAA0000);
    checkOutput("wrOldData", gotData, 32'h11111111);
    applyStimulus(1'b0, 32'h20, 32'h0);
    checkOutput("rdData20", gotData, 32'hAAAA0000);

    // Misaligned write is rejected and leaves the word untouched.
    applyStimulus(1'b1, 32'h22, 32'hFFFFFFFF);
    checkBit("misErr", gotErr, 1'b1);
    checkOutput("misRdata", gotData, 32'h0);
    checkOutput("misCycle", 32'(gotCycle), 32'd4);
    applyStimulus(1'b0, 32'h20, 32'h0);
    checkOutput("misNoWrite", gotData, 32'hAAAA0000);
    checkBit("misErrClears", gotErr, 1'b0);

    // 0x100 aliases word 0 with 64 words of storage.
    applyStimulus(1'b1, 32'h100, 32'h5);
    applyStimulus(1'b0, 32'h000, 32'h0);
    checkOutput("aliasData", gotData, 32'h5);

    // LATENCY=0 with the request held: accept every other cycle.
    @(negedge clk);
    zWe = 1'b1; zAddr = 32'h0C; zWdata = 32'h77; zValid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checkBit($sformatf("b2bValid%0d", k), zRespValid, 1'(k % 2));
      checkBit($sformatf("b2bReady%0d", k), zReady, 1'(1 - (k % 2)));
      if (k == 3) checkOutput("b2bData", zRespRdata, 32'h77);
    end
    zValid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
